// File: rtl/feeder_pkg.sv
// Shared definitions for the serial word feeder: state encoding and default sizing.
// The counter-width helper keeps the gap counter at least one bit wide even for tiny GAP values.
package feeder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 3;

    function automatic int gap_cnt_width(input int gap);
        return (gap <= 2) ? 1 : $clog2(gap);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shift register; load wins over shift, vacated bits fill with 0.
// MSB_FIRST selects shift direction and which end of the register drives the serial output.
module piso_shift_reg
    import feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    always_comb begin
        shift_d = shift_q;
        if (load_i) begin
            shift_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end else begin
                shift_d = {1'b0, shift_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign bit_o = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

endmodule

// File: rtl/serial_word_feeder.sv
// Serializes buffered words onto the sequence detector input w, then forces GAP zero cycles
// so three consecutive zeros return the detector to its initial state between words.
module serial_word_feeder
    import feeder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int GAP       = DEFAULT_GAP,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w,
    output logic             bit_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int BW      = $clog2(WIDTH);
    localparam int GW      = gap_cnt_width(GAP);
    localparam int GAP_END = (GAP > 0) ? GAP - 1 : 0;

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_END);

    state_e           state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             transfer;
    logic             accept;
    logic             shift_bit;

    assign accept = load_valid & ~buf_full_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        transfer  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (buf_full_q) begin
                    transfer  = 1'b1;
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    if (GAP > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else if (buf_full_q) begin
                        transfer = 1'b1;
                        state_d  = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (buf_full_q) begin
                        transfer  = 1'b1;
                        state_d   = S_SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                // Unused encoding parks the machine back in IDLE with clean counters.
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (transfer) begin
            buf_full_d = 1'b0;
        end else if (accept) begin
            buf_d      = data_in;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shifter (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .load_i  (transfer),
        .shift_i (state_q == S_SHIFT),
        .data_i  (buf_q),
        .bit_o   (shift_bit)
    );

    // All outputs decode registered state only, so w never glitches with handshake inputs.
    assign bit_valid  = (state_q == S_SHIFT);
    assign w          = bit_valid & shift_bit;
    assign word_done  = bit_valid & (bit_cnt_q == BIT_LAST);
    assign load_ready = ~buf_full_q;
    assign busy       = (state_q != S_IDLE) | buf_full_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Directed bench for serial_word_feeder: three instances cover MSB-first, LSB-first and GAP=0.
// Expected serial streams are hand-written constants derived from the test words.
module tb_serial_word_feeder;

    logic Clock;
    logic Reset;

    logic [7:0] msbData, lsbData, ngData;
    logic       msbValid, lsbValid, ngValid;
    logic       msbReady, lsbReady, ngReady;
    logic       msbW, lsbW, ngW;
    logic       msbBitValid, lsbBitValid, ngBitValid;
    logic       msbBusy, lsbBusy, ngBusy;
    logic       msbDone, lsbDone, ngDone;

    int compareCount;
    int mismatchCount;

    serial_word_feeder #(.WIDTH(8), .GAP(3), .MSB_FIRST(1'b1)) u_msb (
        .Clock(Clock), .Reset(Reset), .data_in(msbData), .load_valid(msbValid),
        .load_ready(msbReady), .w(msbW), .bit_valid(msbBitValid), .busy(msbBusy),
        .word_done(msbDone)
    );

    serial_word_feeder #(.WIDTH(8), .GAP(3), .MSB_FIRST(1'b0)) u_lsb (
        .Clock(Clock), .Reset(Reset), .data_in(lsbData), .load_valid(lsbValid),
        .load_ready(lsbReady), .w(lsbW), .bit_valid(lsbBitValid), .busy(lsbBusy),
        .word_done(lsbDone)
    );

    serial_word_feeder #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_nogap (
        .Clock(Clock), .Reset(Reset), .data_in(ngData), .load_valid(ngValid),
        .load_ready(ngReady), .w(ngW), .bit_valid(ngBitValid), .busy(ngBusy),
        .word_done(ngDone)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        compareCount++;
        if ({msbW, msbBitValid, msbDone, msbBusy, msbReady} !== 5'b00001) begin
            mismatchCount++;
            $display("[TB] FAIL reset_msb: got %b expected %b",
                     {msbW, msbBitValid, msbDone, msbBusy, msbReady}, 5'b00001);
        end
        compareCount++;
        if ({lsbW, lsbBitValid, lsbDone, lsbBusy, lsbReady} !== 5'b00001) begin
            mismatchCount++;
            $display("[TB] FAIL reset_lsb: got %b expected %b",
                     {lsbW, lsbBitValid, lsbDone, lsbBusy, lsbReady}, 5'b00001);
        end
        compareCount++;
        if ({ngW, ngBitValid, ngDone, ngBusy, ngReady} !== 5'b00001) begin
            mismatchCount++;
            $display("[TB] FAIL reset_nogap: got %b expected %b",
                     {ngW, ngBitValid, ngDone, ngBusy, ngReady}, 5'b00001);
        end
        Reset = 1'b0;
        step();
        compareCount++;
        if ({msbW, msbBitValid, msbDone, msbBusy, msbReady} !== 5'b00001) begin
            mismatchCount++;
            $display("[TB] FAIL idle_after_reset: got %b expected %b",
                     {msbW, msbBitValid, msbDone, msbBusy, msbReady}, 5'b00001);
        end
    endtask

    task automatic test_msb_word();
        logic [7:0] expSeq;
        expSeq   = 8'b1011_0100;
        msbData  = 8'hB4;
        msbValid = 1'b1;
        step();
        msbValid = 1'b0;
        msbData  = 8'h00;
        compareCount++;
        if ({msbReady, msbBusy, msbBitValid} !== 3'b010) begin
            mismatchCount++;
            $display("[TB] FAIL msb_accept: got %b expected %b",
                     {msbReady, msbBusy, msbBitValid}, 3'b010);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            compareCount++;
            if ({msbW, msbBitValid, msbDone} !== {expSeq[7-i], 1'b1, (i == 7)}) begin
                mismatchCount++;
                $display("[TB] FAIL msb_bit%0d: got %b expected %b", i,
                         {msbW, msbBitValid, msbDone}, {expSeq[7-i], 1'b1, (i == 7)});
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            compareCount++;
            if ({msbW, msbBitValid, msbDone, msbBusy} !== 4'b0001) begin
                mismatchCount++;
                $display("[TB] FAIL msb_gap%0d: got %b expected %b", i,
                         {msbW, msbBitValid, msbDone, msbBusy}, 4'b0001);
            end
        end
        step();
        compareCount++;
        if ({msbBusy, msbReady, msbBitValid} !== 3'b010) begin
            mismatchCount++;
            $display("[TB] FAIL msb_idle: got %b expected %b",
                     {msbBusy, msbReady, msbBitValid}, 3'b010);
        end
    endtask

    task automatic test_lsb_word();
        logic [7:0] expSeq;
        expSeq   = 8'b0010_1101;
        lsbData  = 8'hB4;
        lsbValid = 1'b1;
        step();
        lsbValid = 1'b0;
        lsbData  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            compareCount++;
            if ({lsbW, lsbBitValid, lsbDone} !== {expSeq[7-i], 1'b1, (i == 7)}) begin
                mismatchCount++;
                $display("[TB] FAIL lsb_bit%0d: got %b expected %b", i,
                         {lsbW, lsbBitValid, lsbDone}, {expSeq[7-i], 1'b1, (i == 7)});
            end
        end
        for (int i = 0; i < 4; i++) step();
        compareCount++;
        if ({lsbW, lsbBitValid, lsbBusy} !== 3'b000) begin
            mismatchCount++;
            $display("[TB] FAIL lsb_idle: got %b expected %b",
                     {lsbW, lsbBitValid, lsbBusy}, 3'b000);
        end
    endtask

    // Second word arrives while the first shifts; load_valid stays high with junk while full.
    task automatic test_back_to_back();
        logic [19:0] expW, expBv, expDone, expReady;
        expW     = 20'hFF102;
        expBv    = 20'hFF1FE;
        expDone  = 20'h01002;
        expReady = 20'h801FF;
        msbData  = 8'hFF;
        msbValid = 1'b1;
        step();
        msbData  = 8'h81;
        for (int j = 1; j <= 20; j++) begin
            step();
            compareCount++;
            if ({msbW, msbBitValid, msbDone, msbReady} !==
                {expW[20-j], expBv[20-j], expDone[20-j], expReady[20-j]}) begin
                mismatchCount++;
                $display("[TB] FAIL b2b_cycle%0d: got %b expected %b", j,
                         {msbW, msbBitValid, msbDone, msbReady},
                         {expW[20-j], expBv[20-j], expDone[20-j], expReady[20-j]});
            end
            if (j == 2) msbData = 8'h5A;
            if (j == 11) begin
                msbValid = 1'b0;
                msbData  = 8'h00;
            end
        end
        for (int i = 0; i < 3; i++) step();
        compareCount++;
        if ({msbBusy, msbReady} !== 2'b01) begin
            mismatchCount++;
            $display("[TB] FAIL b2b_idle: got %b expected %b", {msbBusy, msbReady}, 2'b01);
        end
    endtask

    task automatic test_gap_zero();
        logic [15:0] expSeq;
        expSeq  = 16'hAA55;
        ngData  = 8'hAA;
        ngValid = 1'b1;
        step();
        ngData  = 8'h55;
        for (int i = 0; i < 16; i++) begin
            step();
            compareCount++;
            if ({ngW, ngBitValid, ngDone} !== {expSeq[15-i], 1'b1, (i == 7 || i == 15)}) begin
                mismatchCount++;
                $display("[TB] FAIL nogap_bit%0d: got %b expected %b", i,
                         {ngW, ngBitValid, ngDone}, {expSeq[15-i], 1'b1, (i == 7 || i == 15)});
            end
            if (i == 1) begin
                compareCount++;
                if (ngReady !== 1'b0) begin
                    mismatchCount++;
                    $display("[TB] FAIL nogap_second_accept: got %b expected %b", ngReady, 1'b0);
                end
                ngValid = 1'b0;
                ngData  = 8'h00;
            end
        end
        step();
        compareCount++;
        if ({ngBitValid, ngBusy, ngReady} !== 3'b001) begin
            mismatchCount++;
            $display("[TB] FAIL nogap_idle: got %b expected %b",
                     {ngBitValid, ngBusy, ngReady}, 3'b001);
        end
    endtask

    task automatic test_reset_mid_word();
        msbData  = 8'hF0;
        msbValid = 1'b1;
        step();
        msbData  = 8'h0F;
        for (int i = 1; i <= 4; i++) begin
            step();
            compareCount++;
            if ({msbW, msbBitValid} !== 2'b11) begin
                mismatchCount++;
                $display("[TB] FAIL midreset_bit%0d: got %b expected %b", i,
                         {msbW, msbBitValid}, 2'b11);
            end
            if (i == 2) begin
                msbValid = 1'b0;
                msbData  = 8'h00;
            end
        end
        compareCount++;
        if (msbReady !== 1'b0) begin
            mismatchCount++;
            $display("[TB] FAIL midreset_buffered: got %b expected %b", msbReady, 1'b0);
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        compareCount++;
        if ({msbW, msbBitValid, msbDone, msbBusy, msbReady} !== 5'b00001) begin
            mismatchCount++;
            $display("[TB] FAIL midreset_clear: got %b expected %b",
                     {msbW, msbBitValid, msbDone, msbBusy, msbReady}, 5'b00001);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            compareCount++;
            if ({msbW, msbBitValid, msbBusy} !== 3'b000) begin
                mismatchCount++;
                $display("[TB] FAIL midreset_quiet%0d: got %b expected %b", i,
                         {msbW, msbBitValid, msbBusy}, 3'b000);
            end
        end
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        Reset    = 1'b1;
        msbData  = 8'h00; lsbData  = 8'h00; ngData  = 8'h00;
        msbValid = 1'b0;  lsbValid = 1'b0;  ngValid = 1'b0;
        $display("[TB] starting serial_word_feeder bench");
        test_reset();
        test_msb_word();
        test_lsb_word();
        test_back_to_back();
        test_gap_zero();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
